// File: rtl/op_unit.sv
`default_nettype none
// ============================================================================
// Module   : op_unit
// Purpose  : Operational (datapath) unit that sits opposite a microprogrammed
//            control automaton. Each clock it executes the microoperation
//            strobes t1..t9 and returns the branch conditions x and y.
//            State: accumulator A, operand B, carry flag cf, step counter C,
//            and a result latch R with a ready flag rdy. Together these
//            support load / add / shift / counted-loop sequences such as
//            shift-add multiplication.
//
// Ports    : clk            rising-edge clock
//            res            asynchronous active-high reset
//            t1             A <= A + B, carry out into cf
//            t2             C <= C + 1 (wraps)
//            t3             A <= din_a
//            t4             B <= din_b
//            t5             A shift right, cf into MSB
//            t6             B <= B << 1
//            t7             C <= 0
//            t8             cf <= 0
//            t9             R <= A, rdy <= 1
//            din_a[W-1:0]   accumulator load data
//            din_b[W-1:0]   operand load data
//            x              condition A[0]
//            y              condition C == COUNT_LAST
//            result[W-1:0]  latched result R
//            rdy            result valid
//
// Revision : 1.0 - initial release
// ============================================================================
module op_unit #(
    parameter int WIDTH      = 8,
    parameter int CW         = 4,
    parameter int COUNT_LAST = 7
) (
    input  logic             clk,
    input  logic             res,
    input  logic             t1,
    input  logic             t2,
    input  logic             t3,
    input  logic             t4,
    input  logic             t5,
    input  logic             t6,
    input  logic             t7,
    input  logic             t8,
    input  logic             t9,
    input  logic [WIDTH-1:0] din_a,
    input  logic [WIDTH-1:0] din_b,
    output logic             x,
    output logic             y,
    output logic [WIDTH-1:0] result,
    output logic             rdy
);

    localparam logic [CW-1:0] c_C_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] c_C_LAST = CW'(COUNT_LAST);

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_cf;
    logic [CW-1:0]    r_c;
    logic [WIDTH-1:0] r_r;
    logic             r_rdy;

    // ------------------------------------------------------------------------
    // Next-state values; every term reads only pre-edge register values, so
    // strobes fired together never chain through one another.
    // ------------------------------------------------------------------------
    logic [WIDTH:0]   w_sum;    // carry-extended A + B
    logic [WIDTH-1:0] w_a_nxt;
    logic             w_cf_nxt;
    logic [WIDTH-1:0] w_b_nxt;
    logic [CW-1:0]    w_c_nxt;
    logic [WIDTH-1:0] w_r_nxt;
    logic             w_rdy_nxt;

    assign w_sum = {1'b0, r_a} + {1'b0, r_b};

    // Accumulator: load wins; add+shift together keep the carry by taking
    // the upper WIDTH bits of the WIDTH+1-bit sum (one shift-add step).
    always_comb begin
        w_a_nxt = r_a;
        if (t3) begin
            w_a_nxt = din_a;
        end else if (t1 && t5) begin
            w_a_nxt = w_sum[WIDTH:1];
        end else if (t1) begin
            w_a_nxt = w_sum[WIDTH-1:0];
        end else if (t5) begin
            w_a_nxt = {r_cf, r_a[WIDTH-1:1]};
        end
    end

    // Carry flag: only a plain add leaves a carry behind. The combined
    // add+shift has already consumed its carry into A, and a plain shift
    // consumes the old cf into the MSB.
    always_comb begin
        w_cf_nxt = r_cf;
        if (t8 || t3) begin
            w_cf_nxt = 1'b0;
        end else if (t1 && t5) begin
            w_cf_nxt = 1'b0;
        end else if (t1) begin
            w_cf_nxt = w_sum[WIDTH];
        end else if (t5) begin
            w_cf_nxt = 1'b0;
        end
    end

    // Operand register: load over shift-left.
    always_comb begin
        w_b_nxt = r_b;
        if (t4) begin
            w_b_nxt = din_b;
        end else if (t6) begin
            w_b_nxt = {r_b[WIDTH-2:0], 1'b0};
        end
    end

    // Step counter: clear over increment; natural wrap at 2^CW.
    always_comb begin
        w_c_nxt = r_c;
        if (t7) begin
            w_c_nxt = '0;
        end else if (t2) begin
            w_c_nxt = r_c + c_C_ONE;
        end
    end

    // Result latch: t9 captures the pre-edge A and wins over the
    // ready-clearing effect of a fresh accumulator load.
    always_comb begin
        w_r_nxt   = r_r;
        w_rdy_nxt = r_rdy;
        if (t9) begin
            w_r_nxt   = r_a;
            w_rdy_nxt = 1'b1;
        end else if (t3) begin
            w_rdy_nxt = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // State update
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_a   <= '0;
            r_b   <= '0;
            r_cf  <= 1'b0;
            r_c   <= '0;
            r_r   <= '0;
            r_rdy <= 1'b0;
        end else begin
            r_a   <= w_a_nxt;
            r_b   <= w_b_nxt;
            r_cf  <= w_cf_nxt;
            r_c   <= w_c_nxt;
            r_r   <= w_r_nxt;
            r_rdy <= w_rdy_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Conditions and outputs: decoded from registers only, so the automaton
    // sees the post-edge state without any combinational input path.
    // ------------------------------------------------------------------------
    assign x      = r_a[0];
    assign y      = (r_c == c_C_LAST);
    assign result = r_r;
    assign rdy    = r_rdy;

endmodule
`default_nettype wire
